// File: rtl/onehot_enc_stream.sv
// onehot_enc_stream: single-stage valid/ready pipeline that encodes a bit vector
// into a bit index (strict one-hot, LSB-first or MSB-first priority) and keeps
// a saturating count of results flagged as invalid.
module onehot_enc_stream #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MODE      = 0,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clr_err
);

    localparam int unsigned MODE_STRICT = 0;
    localparam int unsigned MODE_LSB    = 1;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    // Pipeline state
    logic                 valid_q, valid_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    // Encoder intermediates
    logic [IDX_W-1:0]     lsb_idx;
    logic [IDX_W-1:0]     msb_idx;
    logic                 any_set;
    logic                 multi_set;
    logic [IDX_W-1:0]     enc_idx;
    logic                 enc_err;

    // Handshake qualifiers
    logic                 in_fire;
    logic                 out_fire;
    logic [ERR_CNT_W-1:0] cnt_base;

    // Upstream may push whenever the holding register is empty or draining
    assign in_ready = !valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

    // Scan the input once: lowest and highest set bit, plus any/multiple flags
    always_comb begin
        lsb_idx   = '0;
        msb_idx   = '0;
        any_set   = 1'b0;
        multi_set = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_data[i]) begin
                if (!any_set) begin
                    lsb_idx = IDX_W'(i);
                end else begin
                    multi_set = 1'b1;
                end
                msb_idx = IDX_W'(i);
                any_set = 1'b1;
            end
        end
    end

    // Select index/error for the configured mode; flagged results carry index 0
    always_comb begin
        enc_err = !any_set;
        enc_idx = msb_idx;
        if (MODE == MODE_STRICT) begin
            enc_err = !any_set || multi_set;
            enc_idx = lsb_idx;
        end else if (MODE == MODE_LSB) begin
            enc_idx = lsb_idx;
        end
        if (enc_err) begin
            enc_idx = '0;
        end
    end

    // Next-state: load on accept, drop valid on a drain with no refill, else hold
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (in_fire) begin
            valid_d = 1'b1;
            idx_d   = enc_idx;
            err_d   = enc_err;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    // Error counter: clear first, then count an accepted error with saturation
    always_comb begin
        cnt_base = clr_err ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (in_fire && enc_err && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + ERR_CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_err   = err_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_onehot_enc_stream.sv
// Bench for onehot_enc_stream: four instances (strict, LSB, MSB, strict with a
// 2-bit counter) share one stimulus stream and are compared to a reference model.
module tb_onehot_enc_stream;

    localparam int unsigned NI = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       clr_err;

    logic       irdy [NI];
    logic       ov   [NI];
    logic [2:0] oi   [NI];
    logic       oe   [NI];
    logic [7:0] ec8  [3];
    logic [1:0] ec2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_mode [NI] = '{0, 1, 2, 0};
    int m_max  [NI] = '{255, 255, 255, 3};
    bit m_valid;
    int m_idx  [NI];
    bit m_err  [NI];
    int m_cnt  [NI];

    onehot_enc_stream #(.WIDTH(8), .MODE(0), .ERR_CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_idx(oi[0]), .out_err(oe[0]), .err_count(ec8[0]), .clr_err(clr_err));
    onehot_enc_stream #(.WIDTH(8), .MODE(1), .ERR_CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_idx(oi[1]), .out_err(oe[1]), .err_count(ec8[1]), .clr_err(clr_err));
    onehot_enc_stream #(.WIDTH(8), .MODE(2), .ERR_CNT_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
        .out_idx(oi[2]), .out_err(oe[2]), .err_count(ec8[2]), .clr_err(clr_err));
    onehot_enc_stream #(.WIDTH(8), .MODE(0), .ERR_CNT_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[3]),
        .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready),
        .out_idx(oi[3]), .out_err(oe[3]), .err_count(ec2), .clr_err(clr_err));

    always #5 clk = ~clk;

    function automatic bit exp_err(input int m, input logic [7:0] d);
        return (d == 8'h00) || ((m == 0) && ($countones(d) > 1));
    endfunction

    // Lowest set bit via isolating it with d & -d; highest via clog2(d+1)-1
    function automatic int exp_idx(input int m, input logic [7:0] d);
        int v;
        v = int'(d);
        if (exp_err(m, d)) return 0;
        if (m == 2) return $clog2(v + 1) - 1;
        return $clog2(v & -v);
    endfunction

    function automatic int cnt_of(input int k);
        if (k < 3) return int'(ec8[k]);
        return int'(ec2);
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, k, obs, expv);
        end
    endtask

    // One clock cycle: drive, check in_ready, advance model, check registered outputs
    task automatic cyc(input logic v, input logic [7:0] d, input logic r,
                       input logic c, input logic rn);
        bit fire_in, fire_out, e;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clr_err   = c;
        rst_n     = rn;
        #1;
        for (int k = 0; k < NI; k++) chk("in_ready", k, 64'(irdy[k]), 64'(!m_valid || r));
        fire_in  = v && (!m_valid || r);
        fire_out = m_valid && r;
        @(posedge clk);
        if (!rn) begin
            m_valid = 0;
            for (int k = 0; k < NI; k++) begin
                m_idx[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                e = fire_in && exp_err(m_mode[k], d);
                if (fire_in) begin
                    m_idx[k] = exp_idx(m_mode[k], d);
                    m_err[k] = exp_err(m_mode[k], d);
                end
                if (c) m_cnt[k] = 0;
                if (e && m_cnt[k] < m_max[k]) m_cnt[k]++;
            end
            if (fire_in) m_valid = 1;
            else if (fire_out) m_valid = 0;
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("out_valid", k, 64'(ov[k]), 64'(m_valid));
            chk("out_idx", k, 64'(oi[k]), 64'(m_idx[k]));
            chk("out_err", k, 64'(oe[k]), 64'(m_err[k]));
            chk("err_count", k, 64'(cnt_of(k)), 64'(m_cnt[k]));
        end
        @(negedge clk);
    endtask

    initial begin
        int exp35 [5] = '{1, 2, 3, 3, 3};
        logic [7:0] d;
        logic [7:0] one;

        clk = 0; rst_n = 0; in_valid = 0; in_data = 0; out_ready = 0; clr_err = 0;
        m_valid = 0;
        for (int k = 0; k < NI; k++) begin
            m_idx[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        // Reset state, with transfer and clr attempted during reset
        cyc(1, 8'h10, 1, 1, 0);
        chk("reset_valid", 0, 64'(ov[0]), 64'(0));
        chk("reset_cnt", 0, 64'(ec8[0]), 64'(0));

        // Single one-hot value
        cyc(1, 8'h10, 1, 0, 1);
        chk("onehot_idx", 0, 64'(oi[0]), 64'(4));
        chk("onehot_err", 0, 64'(oe[0]), 64'(0));
        chk("onehot_cnt", 0, 64'(ec8[0]), 64'(0));

        // Two bits set: strict flags, priority modes pick low/high
        cyc(1, 8'h24, 1, 0, 1);
        chk("multi_err_m0", 0, 64'(oe[0]), 64'(1));
        chk("multi_idx_m0", 0, 64'(oi[0]), 64'(0));
        chk("multi_cnt_m0", 0, 64'(ec8[0]), 64'(1));
        chk("multi_idx_m1", 1, 64'(oi[1]), 64'(2));
        chk("multi_idx_m2", 2, 64'(oi[2]), 64'(5));
        chk("multi_err_m1", 1, 64'(oe[1]), 64'(0));
        chk("multi_err_m2", 2, 64'(oe[2]), 64'(0));

        // Backpressure holds the result and blocks new input
        cyc(1, 8'h01, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 8'h80, 0, 0, 1);
            chk("bp_idx", 0, 64'(oi[0]), 64'(0));
            chk("bp_valid", 0, 64'(ov[0]), 64'(1));
            chk("bp_ready", 0, 64'(irdy[0]), 64'(0));
        end
        cyc(1, 8'h80, 1, 0, 1);
        chk("bp_release_idx", 0, 64'(oi[0]), 64'(7));

        // Streaming one-hot values with no gaps
        for (int i = 0; i < 8; i++) begin
            one = 8'h01;
            cyc(1, one << i, 1, 0, 1);
            chk("stream_idx", 0, 64'(oi[0]), 64'(i));
            chk("stream_valid", 0, 64'(ov[0]), 64'(1));
        end
        cyc(0, 8'h00, 1, 0, 1);
        chk("drain_valid", 0, 64'(ov[0]), 64'(0));

        // Saturation of the 2-bit counter, then clear coincident with an error
        cyc(0, 8'h00, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'h00, 1, 0, 1);
            chk("sat_cnt", 3, 64'(ec2), 64'(exp35[i]));
        end
        cyc(1, 8'h00, 1, 1, 1);
        chk("clr_plus_err", 3, 64'(ec2), 64'(1));

        // Reset while a result is held under backpressure
        cyc(1, 8'h01, 0, 0, 1);
        cyc(1, 8'h02, 0, 0, 0);
        chk("midrst_valid", 0, 64'(ov[0]), 64'(0));
        chk("midrst_cnt", 0, 64'(ec8[0]), 64'(0));
        chk("midrst_ready", 0, 64'(irdy[0]), 64'(1));

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: d = 8'h00;
                1: begin one = 8'h01; d = one << $urandom_range(0, 7); end
                default: d = 8'($urandom);
            endcase
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_enc_stream.md
ONEHOT_ENC_STREAM -- requirements
Module: onehot_enc_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input vector width; legal range 2..64.
REQ-002 SHALL have parameter MODE, default 0: 0 = strict one-hot, 1 = priority LSB-first, 2 = priority MSB-first.
REQ-003 SHALL have parameter ERR_CNT_W, default 8: width of the error counter.
REQ-004 SHALL define localparam IDX_W = $clog2(WIDTH).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset; synchronous and active-low.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  vector to encode.
REQ-010 out_valid  output  1  out_idx/out_err hold a result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_idx  output  IDX_W  encoded bit index.
REQ-013 out_err  output  1  result flagged invalid, per REQ-019.
REQ-014 err_count  output  ERR_CNT_W  saturating count of flagged results.
REQ-015 clr_err  input  1  synchronous clear of err_count.

Function
REQ-016 SHALL accept a transfer when in_valid && in_ready, and emit a result when out_valid && out_ready.
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational): one register stage, full throughput, latency exactly 1 cycle from accept to out_valid.
REQ-018 SHALL register the result on accept: out_valid=1, plus out_idx/out_err computed from in_data.
- MODE 0: out_idx = position of the single set bit.
- MODE 1: out_idx = lowest set bit index.
- MODE 2: out_idx = highest set bit index.
REQ-019 SHALL set out_err=1 when in_data==0 (all modes), or when more than one bit is set (MODE 0 only); out_idx SHALL be 0 whenever out_err=1.
REQ-020 SHALL clear out_valid on a cycle with out_valid && out_ready && !(in_valid && in_ready).
REQ-021 SHALL replace the held result on back-to-back transfers (out_ready=1, in_valid=1): no bubble, no duplication.
REQ-022 SHALL hold out_idx, out_err and out_valid stable while out_valid && !out_ready; in_data changes SHALL have no effect.
REQ-023 SHALL increment err_count by 1 on each accepted transfer whose result has out_err=1, counted at accept time.
REQ-024 SHALL saturate err_count at 2^ERR_CNT_W-1; further errors leave it unchanged.
REQ-025 clr_err SHALL set err_count to 0; if an error is accepted in the same cycle, err_count SHALL become 1.
REQ-026 SHALL produce no X/undefined outputs for any in_data, including values with bits above the highest legal index when WIDTH is not a power of 2.

Reset
REQ-027 While rst_n=0 at a clock edge, SHALL set out_valid=0, out_idx=0, out_err=0, err_count=0.
REQ-028 in_ready SHALL evaluate to 1 during and immediately after reset (since out_valid=0).
REQ-029 Reset asserted mid-transfer SHALL discard the held result without emitting it.
REQ-030 Reset SHALL take priority over clr_err and any simultaneous transfer.

Verification
REQ-031 WIDTH=8, MODE=0: in_data=8'b0001_0000 accepted, out_ready=1 -> next cycle out_valid=1, out_idx=4, out_err=0, err_count=0.
REQ-032 WIDTH=8, MODE=0, 8'b0010_0100 and MODE 1/2 same input -> MODE0 out_err=1/out_idx=0/err_count=1; MODE1 out_idx=2; MODE2 out_idx=5; both out_err=0.
REQ-033 Backpressure: accept 8'h01, hold out_ready=0 for 3 cycles while in_valid=1, in_data=8'h80 -> in_ready=0, out_idx stays 0 for 3 cycles; out_ready=1 -> 8'h80 accepted same cycle, out_idx=7 next cycle.
REQ-034 Streaming: 8 consecutive one-hot inputs 8'h01..8'h80, out_ready=1 -> 8 results out_idx=0..7 on 8 consecutive cycles, no gaps.
REQ-035 ERR_CNT_W=2: 5 accepted in_data=0 -> err_count 1,2,3,3,3; then clr_err coincident with a 6th zero input -> err_count=1.
REQ-036 rst_n=0 for 1 cycle while out_valid=1 and out_ready=0 -> out_valid=0, err_count=0, in_ready=1 next cycle; held result never emitted.
